// File: rtl/biriscv_mule.sv
// Iterative 32x32 extended multiplier for the custom-0 MULE instructions.
// Radix-2 shift-add over 32 cycles, a sign-fix cycle, and a one-entry reuse cache.
module biriscv_mule (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        opcode_valid_i,
   input  logic [31:0] opcode_opcode_i,
   input  logic [31:0] opcode_ra_operand_i,
   input  logic [31:0] opcode_rb_operand_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        mule_complete_o,
   output logic [31:0] mule_result_o
);

   typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

   state_t      state;
   state_t      state_next;

   logic [2:0]  funct3_in;
   logic        accept;
   logic        hit;
   logic        a_signed;
   logic        b_signed;
   logic        neg_in;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic        unused_opcode;

   logic [2:0]  funct3;
   logic [31:0] ra_key;
   logic [31:0] rb_key;
   logic        neg;
   logic [31:0] mcand;
   logic [31:0] mplr;
   logic [63:0] acc;
   logic [4:0]  count;

   logic        cache_valid;
   logic [2:0]  cache_funct3;
   logic [31:0] cache_ra;
   logic [31:0] cache_rb;

   logic [32:0] sum;
   logic [63:0] product;
   logic [31:0] result_sel;

   assign funct3_in     = opcode_opcode_i[14:12];
   assign unused_opcode = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7]};

   assign accept = opcode_valid_i
                && (opcode_opcode_i[6:0] == 7'b0001011)
                && (opcode_opcode_i[31:25] == 7'b0000001)
                && (state == IDLE) && !flush_i;

   // A hit replays the last completion, which is exactly what mule_result_o still holds.
   assign hit = accept && cache_valid
             && (cache_funct3 == funct3_in)
             && (cache_ra == opcode_ra_operand_i)
             && (cache_rb == opcode_rb_operand_i);

   assign a_signed = (funct3_in == 3'b001) || (funct3_in == 3'b010);
   assign b_signed = (funct3_in == 3'b001);
   assign a_abs    = (a_signed && opcode_ra_operand_i[31]) ? (~opcode_ra_operand_i + 32'd1)
                                                          : opcode_ra_operand_i;
   assign b_abs    = (b_signed && opcode_rb_operand_i[31]) ? (~opcode_rb_operand_i + 32'd1)
                                                          : opcode_rb_operand_i;
   assign neg_in   = (a_signed && opcode_ra_operand_i[31]) ^ (b_signed && opcode_rb_operand_i[31]);

   assign sum     = {1'b0, acc[63:32]} + (mplr[0] ? {1'b0, mcand} : 33'd0);
   assign product = neg ? (~acc + 64'd1) : acc;

   always_comb begin
      result_sel = 32'd0;
      case (funct3)
         3'b000:                   result_sel = product[31:0];
         3'b001, 3'b010, 3'b011:   result_sel = product[63:32];
         default:                  result_sel = 32'd0;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && !hit) state_next = BUSY;
         BUSY:    if (count == 5'd31) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i) state_next = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         funct3          <= 3'd0;
         ra_key          <= 32'd0;
         rb_key          <= 32'd0;
         neg             <= 1'b0;
         mcand           <= 32'd0;
         mplr            <= 32'd0;
         acc             <= 64'd0;
         count           <= 5'd0;
         cache_valid     <= 1'b0;
         cache_funct3    <= 3'd0;
         cache_ra        <= 32'd0;
         cache_rb        <= 32'd0;
         mule_complete_o <= 1'b0;
         mule_result_o   <= 32'd0;
      end else begin
         mule_complete_o <= 1'b0;
         if (hit) begin
            mule_complete_o <= 1'b1;
         end else if (accept) begin
            funct3 <= funct3_in;
            ra_key <= opcode_ra_operand_i;
            rb_key <= opcode_rb_operand_i;
            neg    <= neg_in;
            mcand  <= a_abs;
            mplr   <= b_abs;
            acc    <= 64'd0;
            count  <= 5'd0;
         end
         if (state == BUSY && !flush_i) begin
            acc   <= {sum, acc[31:1]};
            mplr  <= {1'b0, mplr[31:1]};
            count <= count + 5'd1;
         end
         if (state == FIX && !flush_i) begin
            mule_result_o   <= result_sel;
            mule_complete_o <= 1'b1;
            cache_valid     <= 1'b1;
            cache_funct3    <= funct3;
            cache_ra        <= ra_key;
            cache_rb        <= rb_key;
         end
      end
   end

endmodule

// File: tb/tb_biriscv_mule.sv
// Directed self-checking bench for biriscv_mule: latency, results, cache reuse,
// flush and asynchronous reset behaviour against hand-computed values.
module tb_biriscv_mule;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [31:0] opcode;
   logic [31:0] ra;
   logic [31:0] rb;
   logic        flush;
   logic        busy;
   logic        complete;
   logic [31:0] result;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   biriscv_mule dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .opcode_valid_i      (valid),
      .opcode_opcode_i     (opcode),
      .opcode_ra_operand_i (ra),
      .opcode_rb_operand_i (rb),
      .flush_i             (flush),
      .busy_o              (busy),
      .mule_complete_o     (complete),
      .mule_result_o       (result)
   );

   function automatic logic [31:0] mk_op(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 10'd0, f3, 5'd0, 7'b0001011};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issues one request, then counts busy cycles and edges until the completion pulse.
   task automatic apply_stimulus(input string tag, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int exp_lat, input logic [31:0] exp_res);
      int lat;
      int busy_cycles;
      opcode = mk_op(7'b0000001, f3);
      ra     = a;
      rb     = b;
      valid  = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      lat         = -1;
      busy_cycles = 0;
      for (int i = 0; i <= 40; i++) begin
         if (complete === 1'b1) begin
            lat = i;
            break;
         end
         if (busy === 1'b1) busy_cycles++;
         @(posedge clk);
         #1;
      end
      check_output({tag, " latency"}, lat, exp_lat);
      check_output({tag, " busy cycles"}, busy_cycles, exp_lat);
      check_output({tag, " result"}, result, exp_res);
      check_output({tag, " busy at completion"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int pulses;
      rst_n  = 1'b0;
      valid  = 1'b0;
      flush  = 1'b0;
      opcode = 32'd0;
      ra     = 32'd0;
      rb     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset busy", {31'd0, busy}, 32'd0);
      check_output("reset complete", {31'd0, complete}, 32'd0);
      check_output("reset result", result, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      apply_stimulus("mule 7xfffffffd", 3'b000, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFEB);
      apply_stimulus("muleh min x min", 3'b001, 32'h80000000, 32'h80000000, 33, 32'h40000000);
      apply_stimulus("muleh -2x3", 3'b001, 32'hFFFFFFFE, 32'd3, 33, 32'hFFFFFFFF);
      apply_stimulus("mulehsu min x 2^31", 3'b010, 32'h80000000, 32'h80000000, 33, 32'hC0000000);
      apply_stimulus("mulehsu -1 x max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFF);
      apply_stimulus("mulehu max x max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
      apply_stimulus("mulehu cache hit", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE);
      apply_stimulus("mulehu rb changed", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32'hFFFFFFFD);

      $display("[TB] flush mid-operation");
      opcode = mk_op(7'b0000001, 3'b011);
      ra     = 32'd5;
      rb     = 32'd7;
      valid  = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check_output("flush busy", {31'd0, busy}, 32'd0);
      check_output("flush complete", {31'd0, complete}, 32'd0);
      check_output("flush result held", result, 32'hFFFFFFFD);
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (complete === 1'b1) pulses++;
      end
      check_output("flush no pulse", pulses, 32'd0);
      apply_stimulus("mule 3x5 after flush", 3'b000, 32'd3, 32'd5, 33, 32'd15);

      $display("[TB] flush with simultaneous request");
      opcode = mk_op(7'b0000001, 3'b000);
      ra     = 32'd9;
      rb     = 32'd9;
      valid  = 1'b1;
      flush  = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      flush = 1'b0;
      check_output("flush+valid busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check_output("flush+valid complete", {31'd0, complete}, 32'd0);

      apply_stimulus("funct3 101", 3'b101, 32'd123, 32'd456, 33, 32'd0);

      $display("[TB] non-MULE opcode");
      opcode = mk_op(7'b0000000, 3'b000);
      ra     = 32'd3;
      rb     = 32'd5;
      valid  = 1'b1;
      @(posedge clk);
      #1;
      check_output("non-mule busy", {31'd0, busy}, 32'd0);
      valid = 1'b0;
      @(posedge clk);
      #1;
      check_output("non-mule complete", {31'd0, complete}, 32'd0);

      apply_stimulus("mule 3x5 refill", 3'b000, 32'd3, 32'd5, 33, 32'd15);

      $display("[TB] asynchronous reset mid-operation");
      opcode = mk_op(7'b0000001, 3'b011);
      ra     = 32'h10;
      rb     = 32'h10;
      valid  = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_output("async reset busy", {31'd0, busy}, 32'd0);
      check_output("async reset complete", {31'd0, complete}, 32'd0);
      check_output("async reset result", result, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_output("post reset complete", {31'd0, complete}, 32'd0);
      apply_stimulus("mule 3x5 after reset", 3'b000, 32'd3, 32'd5, 33, 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
